// File: rtl/spi_mem_pkg.sv
// rtl/spi_mem_pkg.sv - shared types and defaults for the parameter/meter RAM arbiter
package spi_mem_pkg;

   localparam int WORD_WIDTH_DEF = 36;
   localparam int ADDR_WIDTH_DEF = 10;

   typedef enum logic {OWN_DSP, OWN_HOST} owner_e;

   typedef struct packed {
      logic   valid;
      owner_e owner;
   } rd_tag_t;

endpackage

// File: rtl/rd_return_pipe.sv
// rtl/rd_return_pipe.sv - owner tag delay line matching the RAM read latency
module rd_return_pipe
   import spi_mem_pkg::*;
#(
   parameter int RD_LATENCY = 1
) (
   input  logic    clk,
   input  logic    reset_n,
   input  rd_tag_t in_tag,
   output rd_tag_t out_tag
);

   rd_tag_t stage [RD_LATENCY];

   // Shift tags one stage per cycle; reset discards every read still in flight
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < RD_LATENCY; i++) begin
            stage[i] <= '{valid: 1'b0, owner: OWN_DSP};
         end
      end else begin
         stage[0] <= in_tag;
         for (int i = 1; i < RD_LATENCY; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign out_tag = stage[RD_LATENCY-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - host/DSP arbiter in front of the single-port parameter/meter RAM
module mem_port_arbiter
   import spi_mem_pkg::*;
#(
   parameter int WORD_WIDTH   = WORD_WIDTH_DEF,
   parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
   parameter int RD_LATENCY   = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  host_req,
   input  logic                  host_we,
   input  logic [ADDR_WIDTH-1:0] host_addr,
   input  logic [WORD_WIDTH-1:0] host_wdata,
   output logic                  host_gnt,
   output logic                  host_rvalid,
   output logic [WORD_WIDTH-1:0] host_rdata,
   input  logic                  dsp_req,
   input  logic                  dsp_we,
   input  logic [ADDR_WIDTH-1:0] dsp_addr,
   input  logic [WORD_WIDTH-1:0] dsp_wdata,
   output logic                  dsp_gnt,
   output logic                  dsp_rvalid,
   output logic [WORD_WIDTH-1:0] dsp_rdata,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [WORD_WIDTH-1:0] ram_wdata,
   output logic                  ram_we,
   input  logic [WORD_WIDTH-1:0] ram_rdata
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0]      starve_cnt;
   logic                  host_forced;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [WORD_WIDTH-1:0] wdata_q;
   logic [WORD_WIDTH-1:0] host_rdata_q;
   logic [WORD_WIDTH-1:0] dsp_rdata_q;
   rd_tag_t               push_tag;
   rd_tag_t               ret_tag;

   assign host_forced = host_req && dsp_req && (starve_cnt == CNT_MAX);

   // DSP wins contention unless the host has waited out the starvation limit; nothing granted in reset
   always_comb begin
      dsp_gnt  = reset_n && dsp_req && !host_forced;
      host_gnt = reset_n && host_req && (!dsp_req || host_forced);
   end

   // Steer the granted requester onto the RAM; idle cycles keep the last address/data
   always_comb begin
      ram_addr  = addr_q;
      ram_wdata = wdata_q;
      ram_we    = 1'b0;
      if (dsp_gnt) begin
         ram_addr  = dsp_addr;
         ram_wdata = dsp_wdata;
         ram_we    = dsp_we;
      end else if (host_gnt) begin
         ram_addr  = host_addr;
         ram_wdata = host_wdata;
         ram_we    = host_we;
      end
   end

   // Remember the last driven address/data so idle cycles do not toggle the RAM bus
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (dsp_gnt || host_gnt) begin
         addr_q  <= ram_addr;
         wdata_q <= ram_wdata;
      end
   end

   // Count DSP grants taken while the host waits; saturates so the host is forced next
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         starve_cnt <= '0;
      end else if (host_gnt || !host_req) begin
         starve_cnt <= '0;
      end else if (dsp_gnt && (starve_cnt != CNT_MAX)) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   // Only reads carry a valid tag; writes produce nothing on the return side
   always_comb begin
      push_tag.valid = (dsp_gnt && !dsp_we) || (host_gnt && !host_we);
      push_tag.owner = host_gnt ? OWN_HOST : OWN_DSP;
   end

   rd_return_pipe #(
      .RD_LATENCY (RD_LATENCY)
   ) u_rd_return_pipe (
      .clk     (clk),
      .reset_n (reset_n),
      .in_tag  (push_tag),
      .out_tag (ret_tag)
   );

   assign host_rvalid = ret_tag.valid && (ret_tag.owner == OWN_HOST);
   assign dsp_rvalid  = ret_tag.valid && (ret_tag.owner == OWN_DSP);
   assign host_rdata  = host_rvalid ? ram_rdata : host_rdata_q;
   assign dsp_rdata   = dsp_rvalid ? ram_rdata : dsp_rdata_q;

   // Hold each requester's last returned word while the other side is being served
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         host_rdata_q <= '0;
         dsp_rdata_q  <= '0;
      end else begin
         if (host_rvalid) host_rdata_q <= ram_rdata;
         if (dsp_rvalid)  dsp_rdata_q  <= ram_rdata;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with a write-first RAM model
module tb_mem_port_arbiter;

   localparam int WW     = 36;
   localparam int AW     = 10;
   localparam int STARVE = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          host_req, host_we, dsp_req, dsp_we;
   logic [AW-1:0] host_addr, dsp_addr;
   logic [WW-1:0] host_wdata, dsp_wdata;
   logic          host_gnt, host_rvalid, dsp_gnt, dsp_rvalid;
   logic [WW-1:0] host_rdata, dsp_rdata;
   logic [AW-1:0] ram_addr;
   logic [WW-1:0] ram_wdata;
   logic          ram_we;
   logic [WW-1:0] ram_rdata;

   logic [WW-1:0] ram_mem [1024];
   logic [WW-1:0] shadow  [1024];
   logic [WW-1:0] host_q [$];
   logic [WW-1:0] dsp_q  [$];
   int            cnt;
   int            total = 0;
   int            bad   = 0;
   logic          h_rv_seen, d_rv_seen;

   mem_port_arbiter #(
      .WORD_WIDTH   (WW),
      .ADDR_WIDTH   (AW),
      .RD_LATENCY   (1),
      .STARVE_LIMIT (STARVE)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .host_req    (host_req),
      .host_we     (host_we),
      .host_addr   (host_addr),
      .host_wdata  (host_wdata),
      .host_gnt    (host_gnt),
      .host_rvalid (host_rvalid),
      .host_rdata  (host_rdata),
      .dsp_req     (dsp_req),
      .dsp_we      (dsp_we),
      .dsp_addr    (dsp_addr),
      .dsp_wdata   (dsp_wdata),
      .dsp_gnt     (dsp_gnt),
      .dsp_rvalid  (dsp_rvalid),
      .dsp_rdata   (dsp_rdata),
      .ram_addr    (ram_addr),
      .ram_wdata   (ram_wdata),
      .ram_we      (ram_we),
      .ram_rdata   (ram_rdata)
   );

   always #5 clk = ~clk;

   // Write-first single-port RAM, one cycle read latency
   always @(posedge clk) begin
      if (ram_we) begin
         ram_mem[ram_addr] <= ram_wdata;
         ram_rdata         <= ram_wdata;
      end else begin
         ram_rdata <= ram_mem[ram_addr];
      end
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic set_host(input logic req, input logic we, input logic [AW-1:0] a, input logic [WW-1:0] d);
      host_req = req; host_we = we; host_addr = a; host_wdata = d;
   endtask

   task automatic set_dsp(input logic req, input logic we, input logic [AW-1:0] a, input logic [WW-1:0] d);
      dsp_req = req; dsp_we = we; dsp_addr = a; dsp_wdata = d;
   endtask

   // One cycle: score returns, predict and check grants, then advance past the next edge
   task automatic step();
      logic          exp_d, exp_h;
      logic [WW-1:0] e;
      @(negedge clk);
      h_rv_seen = host_rvalid;
      d_rv_seen = dsp_rvalid;
      if (host_rvalid) begin
         if (host_q.size() == 0) check("host_spurious_rvalid", 1, 0);
         else begin e = host_q.pop_front(); check("host_rdata", host_rdata, e); end
      end
      if (dsp_rvalid) begin
         if (dsp_q.size() == 0) check("dsp_spurious_rvalid", 1, 0);
         else begin e = dsp_q.pop_front(); check("dsp_rdata", dsp_rdata, e); end
      end
      exp_d = reset_n && dsp_req && !(host_req && cnt == STARVE);
      exp_h = reset_n && host_req && !exp_d;
      check("dsp_gnt", dsp_gnt, exp_d);
      check("host_gnt", host_gnt, exp_h);
      check("ram_we", ram_we, (exp_d && dsp_we) || (exp_h && host_we));
      if (exp_d) begin
         check("ram_addr_dsp", ram_addr, dsp_addr);
         if (dsp_we) begin
            check("ram_wdata_dsp", ram_wdata, dsp_wdata);
            shadow[dsp_addr] = dsp_wdata;
         end else dsp_q.push_back(shadow[dsp_addr]);
      end
      if (exp_h) begin
         check("ram_addr_host", ram_addr, host_addr);
         if (host_we) begin
            check("ram_wdata_host", ram_wdata, host_wdata);
            shadow[host_addr] = host_wdata;
         end else host_q.push_back(shadow[host_addr]);
      end
      if (!reset_n || exp_h || !host_req) cnt = 0;
      else if (exp_d && cnt < STARVE) cnt++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         ram_mem[i] = '0;
         shadow[i]  = '0;
      end
      cnt = 0;
      reset_n = 1'b0;
      set_host(1'b1, 1'b0, 10'h000, '0);
      set_dsp(1'b1, 1'b0, 10'h000, '0);

      // Reset with both requesting: nothing granted, returns idle
      repeat (2) step();
      @(negedge clk);
      check("rst_host_rvalid", host_rvalid, 0);
      check("rst_dsp_rvalid", dsp_rvalid, 0);
      check("rst_host_rdata", host_rdata, 0);
      check("rst_dsp_rdata", dsp_rdata, 0);
      check("rst_ram_we", ram_we, 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      step();
      set_host(1'b0, 1'b0, 10'h000, '0);
      set_dsp(1'b0, 1'b0, 10'h000, '0);
      repeat (2) step();

      // Host alone: write then read back, one-cycle return
      set_host(1'b1, 1'b1, 10'h005, 36'h123456789);
      step();
      set_host(1'b1, 1'b0, 10'h005, '0);
      step();
      set_host(1'b0, 1'b0, 10'h005, '0);
      step();
      check("host_rd_latency", h_rv_seen, 1);
      check("dsp_rvalid_quiet", d_rv_seen, 0);
      step();

      // Starvation: both held, host forced every fifth grant
      set_dsp(1'b1, 1'b0, 10'h001, '0);
      set_host(1'b1, 1'b0, 10'h005, '0);
      repeat (12) step();
      set_dsp(1'b0, 1'b0, 10'h001, '0);
      set_host(1'b0, 1'b0, 10'h005, '0);
      repeat (2) step();

      // Interleave: preload then alternate DSP/host reads
      set_host(1'b1, 1'b1, 10'h010, 36'h00000000A);
      step();
      set_host(1'b1, 1'b1, 10'h020, 36'h00000000B);
      step();
      set_host(1'b0, 1'b0, 10'h020, '0);
      for (int i = 0; i < 4; i++) begin
         set_host(1'b0, 1'b0, 10'h020, '0);
         set_dsp(1'b1, 1'b0, 10'h010, '0);
         step();
         set_dsp(1'b0, 1'b0, 10'h010, '0);
         set_host(1'b1, 1'b0, 10'h020, '0);
         step();
      end
      set_host(1'b0, 1'b0, 10'h020, '0);
      repeat (2) step();

      // Read-after-write across requesters
      set_dsp(1'b1, 1'b1, 10'h3FF, 36'h0FFFFFFFF);
      step();
      set_dsp(1'b0, 1'b0, 10'h3FF, '0);
      set_host(1'b1, 1'b0, 10'h3FF, '0);
      step();
      set_host(1'b0, 1'b0, 10'h3FF, '0);
      repeat (2) step();

      // Reset while a host read is in flight: the return is dropped
      set_host(1'b1, 1'b0, 10'h020, '0);
      step();
      set_host(1'b0, 1'b0, 10'h020, '0);
      reset_n = 1'b0;
      host_q.delete();
      dsp_q.delete();
      step();
      check("midrst_host_rvalid", h_rv_seen, 0);
      step();
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("post_rst_host_rvalid", h_rv_seen, 0);
      end

      check("host_q_drained", host_q.size(), 0);
      check("dsp_q_drained", dsp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
